// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct constants, and the mux-select encodings used by the PC mux and datapath.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEX   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_IMMWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_JR     = 4'd12,
    ST_EXC    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] PCSRC_ALURES = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_RS     = 3'b011;
  localparam logic [2:0] PCSRC_EXC    = 3'b100;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] ALUSRCB_REG      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
  localparam logic [1:0] ALUSRCB_SEXT     = 2'b10;
  localparam logic [1:0] ALUSRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  // Branch condition: beq takes the branch on zero, bne on not-zero.
  function automatic logic branch_taken(input logic [5:0] op, input logic zero);
    if (op == OP_BNE) begin
      return ~zero;
    end else begin
      return zero;
    end
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_outdec.sv
// State-to-outputs decode for the multicycle controller; purely combinational,
// with every output forced low while reset is held.
module mc_outdec
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  regdst,
  output logic [1:0]  alusrcb,
  output logic [2:0]  aluop,
  output logic [2:0]  pcsrc,
  output logic        exc
);

  logic       pcen_s, iord_s, memwrite_s, irwrite_s, regwrite_s, memtoreg_s, alusrca_s, exc_s;
  logic [1:0] regdst_s, alusrcb_s;
  logic [2:0] aluop_s, pcsrc_s;

  // Per-state strobe and select decode; anything not set stays at zero.
  always_comb begin
    pcen_s     = 1'b0;
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memtoreg_s = 1'b0;
    alusrca_s  = 1'b0;
    exc_s      = 1'b0;
    regdst_s   = 2'b00;
    alusrcb_s  = 2'b00;
    aluop_s    = 3'b000;
    pcsrc_s    = 3'b000;
    case (state)
      ST_FETCH: begin
        alusrcb_s = ALUSRCB_FOUR;
        aluop_s   = ALUOP_ADD;
        pcsrc_s   = PCSRC_ALURES;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
      end
      ST_DECODE: begin
        alusrcb_s = ALUSRCB_SEXT_SH2;
        aluop_s   = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = ALUSRCB_SEXT;
        aluop_s   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        iord_s = 1'b1;
      end
      ST_MEMWB: begin
        regdst_s   = REGDST_RT;
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      ST_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      ST_RTEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = ALUSRCB_REG;
        aluop_s   = ALUOP_FUNCT;
      end
      ST_RTWB: begin
        regdst_s   = REGDST_RD;
        regwrite_s = 1'b1;
      end
      ST_IMMWB: begin
        regdst_s   = REGDST_RT;
        regwrite_s = 1'b1;
      end
      ST_BRANCH: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = PCSRC_ALUOUT;
        pcen_s    = branch_taken(op, zero);
      end
      ST_JUMP: begin
        pcsrc_s = PCSRC_JUMP;
        pcen_s  = 1'b1;
      end
      ST_JR: begin
        pcsrc_s = PCSRC_RS;
        pcen_s  = 1'b1;
      end
      ST_EXC: begin
        pcsrc_s = PCSRC_EXC;
        pcen_s  = 1'b1;
        exc_s   = 1'b1;
      end
      default: begin
        pcen_s = 1'b0;
      end
    endcase
  end

  assign pcen     = pcen_s     & ~reset;
  assign iord     = iord_s     & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memtoreg = memtoreg_s & ~reset;
  assign alusrca  = alusrca_s  & ~reset;
  assign exc      = exc_s      & ~reset;
  assign regdst   = regdst_s   & {2{~reset}};
  assign alusrcb  = alusrcb_s  & {2{~reset}};
  assign aluop    = aluop_s    & {3{~reset}};
  assign pcsrc    = pcsrc_s    & {3{~reset}};

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: state register and next-state logic; output
// decode lives in mc_outdec.
module mc_ctrl_fsm
  import mips_pkg::*;
#(
  parameter logic EXC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  regdst,
  output logic [1:0]  alusrcb,
  output logic [2:0]  aluop,
  output logic [2:0]  pcsrc,
  output logic        exc
);

  state_t state_r;
  state_t state_nxt_s;

  // State register; reset always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt_s = ST_MEMADR;
          OP_RTYPE: begin
            if (funct == FUNCT_JR) begin
              state_nxt_s = ST_JR;
            end else begin
              state_nxt_s = ST_RTEX;
            end
          end
          OP_BEQ, OP_BNE: state_nxt_s = ST_BRANCH;
          OP_ADDI:        state_nxt_s = ST_ADDIEX;
          OP_J:           state_nxt_s = ST_JUMP;
          default: begin
            // Undefined opcode: trap, or fall through as a NOP.
            if (EXC_EN) begin
              state_nxt_s = ST_EXC;
            end else begin
              state_nxt_s = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEMADR: begin
        if (op == OP_LW) begin
          state_nxt_s = ST_MEMRD;
        end else begin
          state_nxt_s = ST_MEMWR;
        end
      end
      ST_MEMRD: begin
        if (mem_ready) begin
          state_nxt_s = ST_MEMWB;
        end else begin
          state_nxt_s = ST_MEMRD;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_MEMWR;
        end
      end
      ST_RTEX:   state_nxt_s = ST_RTWB;
      ST_ADDIEX: state_nxt_s = ST_IMMWB;
      ST_MEMWB, ST_RTWB, ST_IMMWB, ST_BRANCH, ST_JUMP, ST_JR, ST_EXC: state_nxt_s = ST_FETCH;
      default:   state_nxt_s = ST_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_r),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pcen      (pcen),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .regdst    (regdst),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .exc       (exc)
  );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control word and checks both EXC_EN settings.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] regdst;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [2:0] pcsrc;
    logic       exc;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pcen1, iord1, memwrite1, irwrite1, regwrite1, memtoreg1, alusrca1, exc1;
  logic [1:0] regdst1, alusrcb1;
  logic [2:0] aluop1, pcsrc1;
  logic       pcen0, iord0, memwrite0, irwrite0, regwrite0, memtoreg0, alusrca0, exc0;
  logic [1:0] regdst0, alusrcb0;
  logic [2:0] aluop0, pcsrc0;

  outs_t obs1, obs0, observed;
  logic  use_dut0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen1), .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1),
    .regwrite(regwrite1), .memtoreg(memtoreg1), .alusrca(alusrca1), .regdst(regdst1),
    .alusrcb(alusrcb1), .aluop(aluop1), .pcsrc(pcsrc1), .exc(exc1)
  );

  mc_ctrl_fsm #(.EXC_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen0), .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0),
    .regwrite(regwrite0), .memtoreg(memtoreg0), .alusrca(alusrca0), .regdst(regdst0),
    .alusrcb(alusrcb0), .aluop(aluop0), .pcsrc(pcsrc0), .exc(exc0)
  );

  assign obs1 = {pcen1, iord1, memwrite1, irwrite1, regwrite1, memtoreg1, alusrca1,
                 regdst1, alusrcb1, aluop1, pcsrc1, exc1};
  assign obs0 = {pcen0, iord0, memwrite0, irwrite0, regwrite0, memtoreg0, alusrca0,
                 regdst0, alusrcb0, aluop0, pcsrc0, exc0};
  assign observed = use_dut0 ? obs0 : obs1;

  task automatic chk(input string tag, input outs_t got, input outs_t expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got=%05h exp=%05h (pcen iord mw irw rw m2r asa rd[2] asb[2] aop[3] pcs[3] exc)",
               tag, got, expv);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_def(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100) ||
           (o == 6'b000101) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  task automatic step(input logic mr, input logic z, input outs_t e, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    chk(tag, observed, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    outs_t e;
    e = '0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(rb(), rb(), e, "reset_outs");
    reset = 1'b0;
  endtask

  // Expected cycle sequence of one instruction; nf/nw are memory wait cycles in
  // fetch and in the data access, bz is the zero flag seen during a branch.
  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                           input int nf, input int nw, input logic bz, input logic exc_en);
    outs_t e;
    op = op_v;
    funct = funct_v;
    for (int i = 0; i < nf; i++) begin
      e = '0; e.alusrcb = 2'b01;
      step(1'b0, rb(), e, "fetch_wait");
    end
    e = '0; e.alusrcb = 2'b01; e.pcen = 1'b1; e.irwrite = 1'b1;
    step(1'b1, rb(), e, "fetch");
    e = '0; e.alusrcb = 2'b11;
    step(rb(), rb(), e, "decode");
    if (op_v == 6'b100011 || op_v == 6'b101011) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(rb(), rb(), e, "memadr");
      e = '0; e.iord = 1'b1; e.memwrite = (op_v == 6'b101011);
      for (int i = 0; i < nw; i++) step(1'b0, rb(), e, "mem_wait");
      step(1'b1, rb(), e, "mem_done");
      if (op_v == 6'b100011) begin
        e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
        step(rb(), rb(), e, "memwb");
      end
    end else if (op_v == 6'b000000) begin
      if (funct_v == 6'b001000) begin
        e = '0; e.pcsrc = 3'b011; e.pcen = 1'b1;
        step(rb(), rb(), e, "jr");
      end else begin
        e = '0; e.alusrca = 1'b1; e.aluop = 3'b010;
        step(rb(), rb(), e, "rtex");
        e = '0; e.regdst = 2'b01; e.regwrite = 1'b1;
        step(rb(), rb(), e, "rtwb");
      end
    end else if (op_v == 6'b001000) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(rb(), rb(), e, "addiex");
      e = '0; e.regwrite = 1'b1;
      step(rb(), rb(), e, "immwb");
    end else if (op_v == 6'b000100 || op_v == 6'b000101) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 3'b001;
      e.pcen = (op_v == 6'b000100) ? bz : ~bz;
      step(rb(), bz, e, "branch");
    end else if (op_v == 6'b000010) begin
      e = '0; e.pcsrc = 3'b010; e.pcen = 1'b1;
      step(rb(), rb(), e, "jump");
    end else if (exc_en) begin
      e = '0; e.pcsrc = 3'b100; e.pcen = 1'b1; e.exc = 1'b1;
      step(rb(), rb(), e, "exc");
    end
  endtask

  task automatic rand_instr(input logic exc_en);
    logic [5:0] o;
    logic [5:0] f;
    int         k;
    k = $urandom_range(0, 7);
    case (k)
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: o = 6'b000000;
      3: o = 6'b001000;
      4: o = 6'b000100;
      5: o = 6'b000101;
      6: o = 6'b000010;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (is_def(o)) o = 6'($urandom_range(0, 63));
      end
    endcase
    f = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
    run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), rb(), exc_en);
  endtask

  initial begin
    outs_t e;
    use_dut0  = 1'b0;
    reset     = 1'b1;
    op        = 6'b000000;
    funct     = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed cases on the trapping controller.
    run_instr(6'b100011, 6'b000000, 0, 0, 1'b0, 1'b1);
    run_instr(6'b101011, 6'b000000, 0, 3, 1'b0, 1'b1);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1, 1'b1);
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b1, 1'b1);
    run_instr(6'b000000, 6'b001000, 0, 0, 1'b0, 1'b1);
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) rand_instr(1'b1);

    // Reset while a store is stalled: memwrite must drop straight into FETCH.
    op = 6'b101011;
    e = '0; e.alusrcb = 2'b01; e.pcen = 1'b1; e.irwrite = 1'b1;
    step(1'b1, 1'b0, e, "rst_fetch");
    e = '0; e.alusrcb = 2'b11;
    step(1'b0, 1'b0, e, "rst_decode");
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(1'b0, 1'b0, e, "rst_memadr");
    e = '0; e.iord = 1'b1; e.memwrite = 1'b1;
    step(1'b0, 1'b0, e, "rst_memwr");
    reset = 1'b1;
    e = '0;
    step(1'b0, 1'b0, e, "rst_in_memwr");
    reset = 1'b0;
    e = '0; e.alusrcb = 2'b01;
    step(1'b0, 1'b0, e, "rst_after_memwr");

    // Non-trapping controller: undefined opcodes behave as NOPs.
    use_dut0 = 1'b1;
    do_reset(2);
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b100011, 6'b000000, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) rand_instr(1'b0);
    e = '0; e.alusrcb = 2'b01;
    step(1'b0, 1'b0, e, "final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter: EXC_EN, default 1, 1 = undefined opcode traps to the exception vector; 0 = undefined opcode is treated as a NOP.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode from the instruction register.
REQ-005 funct  in  6  R-type function field.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 pcen  out  1  PC register enable.
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 memwrite, irwrite, regwrite, memtoreg, alusrca  out  1 each  standard datapath strobes and selects.
REQ-011 regdst  out  2  destination register select: 00 = rt, 01 = rd.
REQ-012 alusrcb  out  2  ALU B select: 00 = reg, 01 = const 4, 10 = signext, 11 = signext<<2.
REQ-013 aluop  out  3  000 = add, 001 = sub, 010 = decode by funct.
REQ-014 pcsrc  out  3  select for the downstream 5-input PC mux: 000 = ALUResult, 001 = ALUOut, 010 = jump target, 011 = rs (jr), 100 = exception vector.
REQ-015 exc  out  1  one-cycle pulse when an undefined opcode traps.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, ADDIEX, IMMWB, BRANCH, JUMP, JR, EXC.
REQ-017 In any state not listed below, every output is 0, including 3'b000 on all multi-bit outputs.
REQ-018 FETCH: iord = 0, alusrca = 0, alusrcb = 01, aluop = 000, pcsrc = 000.
REQ-019 FETCH: irwrite and pcen = mem_ready.
REQ-020 FETCH: stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
REQ-021 DECODE: alusrcb = 11, aluop = 000 (branch target to ALUOut).
REQ-022 DECODE next state: lw/sw -> MEMADR; op 000000 with funct 001000 -> JR; other op 000000 -> RTEX; beq/bne -> BRANCH; addi -> ADDIEX; j -> JUMP.
REQ-023 DECODE, any other op: EXC if EXC_EN = 1, else FETCH.
REQ-024 MEMADR: alusrca = 1, alusrcb = 10, aluop = 000; lw -> MEMRD, sw -> MEMWR.
REQ-025 MEMRD: iord = 1; hold until mem_ready = 1, then go to MEMWB.
REQ-026 MEMWB: regdst = 00, memtoreg = 1, regwrite = 1; then go to FETCH.
REQ-027 MEMWR: iord = 1 and memwrite = 1 held for every cycle until mem_ready = 1, then go to FETCH.
REQ-028 RTEX: alusrca = 1, alusrcb = 00, aluop = 010; then go to RTWB.
REQ-029 RTWB: regdst = 01, regwrite = 1; then go to FETCH.
REQ-030 ADDIEX: alusrca = 1, alusrcb = 10, aluop = 000; then go to IMMWB.
REQ-031 IMMWB: regdst = 00, regwrite = 1; then go to FETCH.
REQ-032 BRANCH: alusrca = 1, aluop = 001, pcsrc = 001.
REQ-033 BRANCH: pcen = zero for beq, pcen = ~zero for bne; then go to FETCH.
REQ-034 JUMP: pcsrc = 010, pcen = 1; then go to FETCH.
REQ-035 JR: pcsrc = 011, pcen = 1; then go to FETCH.
REQ-036 EXC: pcsrc = 100, pcen = 1, exc = 1 for exactly one cycle; then go to FETCH.
REQ-037 All outputs are combinational decodes of the current state plus op, zero and mem_ready.
REQ-038 pcsrc never takes a value above 3'b100.
REQ-039 Instruction latency in cycles, with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jr 3, exception 3.
REQ-040 Each memory wait cycle adds exactly one cycle of latency.

Reset
REQ-041 With reset = 1 at a clock edge, the next state is FETCH regardless of current state or inputs.
REQ-042 While reset = 1, all outputs are forced to 0.
REQ-043 Reset asserted mid-MEMWR drops memwrite in the first cycle after the edge.
REQ-044 The state register has no reset-free path.

Structure
REQ-045 The state enum, opcode/funct constants, and pcsrc/aluop/alusrcb encodings live in the shared package mips_pkg.
REQ-046 The PC mux and the datapath import the encodings from mips_pkg.
REQ-047 One sub-module, mc_outdec, holds the state-to-outputs decode; the next-state register and logic stay in mc_ctrl_fsm.

Verification
REQ-048 Reset then lw (op 100011) with mem_ready = 1 throughout -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite = 1 and memtoreg = 1 in cycle 5 only.
REQ-049 sw with mem_ready low for 3 cycles in MEMWR -> memwrite = 1 for 4 consecutive cycles, then FETCH.
REQ-050 beq with zero = 1 -> pcen = 1, pcsrc = 001 in cycle 3.
REQ-051 bne with zero = 1 -> pcen = 0 in cycle 3.
REQ-052 op 000000, funct 001000 -> JR with pcsrc = 011, pcen = 1.
REQ-053 op 111111 -> EXC_EN = 1: pcsrc = 100, exc pulse of 1 cycle; EXC_EN = 0: back to FETCH after DECODE, no pcen.
REQ-054 Reset asserted while in MEMWR with mem_ready = 0 -> next cycle FETCH, memwrite = 0.
